// File: rtl/vlsu_pkg.sv
// Shared types and sizing for the vector load/store unit.
// Address arithmetic wraps at ADDR_W bits; register indices wrap at NUM_VREGS.
package vlsu_pkg;

  localparam int ADDR_W    = 9;
  localparam int VEC_BITS  = 512;
  localparam int NUM_VREGS = 4;
  localparam int REG_W     = $clog2(NUM_VREGS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } state_t;

  // Explicit wrap so a non-power-of-two register count still cycles correctly
  function automatic logic [REG_W-1:0] next_reg(input logic [REG_W-1:0] r);
    if (int'(r) == NUM_VREGS - 1) return '0;
    return r + REG_W'(1);
  endfunction

endpackage

// File: rtl/vlsu_agu.sv
// Address generator: holds the current Dmem word address and vector register
// index, loaded with the command base and advanced by stride once per beat.
module vlsu_agu
  import vlsu_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_stride,
  input  logic [REG_W-1:0]  i_reg,
  output logic [ADDR_W-1:0] o_addr,
  output logic [REG_W-1:0]  o_reg
);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_stride;
  logic [REG_W-1:0]  r_reg;

  // Repeated addition replaces base + k*stride; overflow wraps naturally
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_addr   <= '0;
      r_stride <= '0;
      r_reg    <= '0;
    end else if (i_load) begin
      r_addr   <= i_base;
      r_stride <= i_stride;
      r_reg    <= i_reg;
    end else if (i_step) begin
      r_addr <= r_addr + r_stride;
      r_reg  <= next_reg(r_reg);
    end
  end

  assign o_addr = r_addr;
  assign o_reg  = r_reg;

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: runs one command of 1..4 vector beats between the
// data memory port and the vector register file, one beat per clock.
module vector_lsu
  import vlsu_pkg::*;
(
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_store,
  input  logic [ADDR_W-1:0]   i_cmd_addr,
  input  logic [ADDR_W-1:0]   i_cmd_stride,
  input  logic [1:0]          i_cmd_count,
  input  logic [REG_W-1:0]    i_cmd_reg,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_mem_re,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_address,
  output logic [VEC_BITS-1:0] o_mem_write_data,
  input  logic [VEC_BITS-1:0] i_mem_data_out,
  output logic [REG_W-1:0]    o_rf_raddr,
  input  logic [VEC_BITS-1:0] i_rf_rdata,
  output logic                o_rf_we,
  output logic [REG_W-1:0]    o_rf_waddr,
  output logic [VEC_BITS-1:0] o_rf_wdata
);

  state_t            r_state;
  logic [1:0]        r_beat;
  logic [1:0]        r_count;
  logic              r_done;

  logic              w_accept;
  logic              w_in_beat;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [REG_W-1:0]  w_reg;

  assign w_accept  = (r_state == IDLE) && i_cmd_valid;
  assign w_in_beat = (r_state != IDLE);
  assign w_last    = (r_beat == r_count);

  vlsu_agu u_agu (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_load   (w_accept),
    .i_step   (w_in_beat),
    .i_base   (i_cmd_addr),
    .i_stride (i_cmd_stride),
    .i_reg    (i_cmd_reg),
    .o_addr   (w_addr),
    .o_reg    (w_reg)
  );

  // done is cleared every edge so it can only live for the cycle after the last beat
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_cmd_valid) begin
            r_beat  <= '0;
            r_count <= i_cmd_count;
            r_state <= i_cmd_store ? STORE : LOAD;
          end
        end
        LOAD, STORE: begin
          if (w_last) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else begin
            r_beat <= r_beat + 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready   = (r_state == IDLE);
  assign o_busy        = (r_state != IDLE);
  assign o_done        = r_done;
  assign o_mem_re      = (r_state == LOAD);
  assign o_mem_we      = (r_state == STORE);
  assign o_rf_we       = (r_state == LOAD);
  assign o_mem_address = w_addr;
  assign o_rf_raddr    = w_reg;
  assign o_rf_waddr    = w_reg;

  // Data paths are forced to zero outside their beat type
  assign o_rf_wdata       = (r_state == LOAD)  ? i_mem_data_out : '0;
  assign o_mem_write_data = (r_state == STORE) ? i_rf_rdata     : '0;

endmodule

// File: tb/tb_vector_lsu.sv
// Bench for vector_lsu: behavioural Dmem and register file around the DUT,
// checked against golden memory/register arrays updated per command.
module tb_vector_lsu;
  import vlsu_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_store = 1'b0;
  logic [8:0]   cmd_addr = '0;
  logic [8:0]   cmd_stride = '0;
  logic [1:0]   cmd_count = '0;
  logic [1:0]   cmd_reg = '0;
  logic         busy, done, mem_re, mem_we, rf_we;
  logic [8:0]   mem_address;
  logic [511:0] mem_write_data, mem_data_out, rf_rdata, rf_wdata;
  logic [1:0]   rf_raddr, rf_waddr;

  int checks = 0;
  int errors = 0;

  logic [31:0]  dmem [0:511];
  logic [31:0]  gmem [0:511];
  logic [511:0] vrf  [0:3];
  logic [511:0] gvrf [0:3];

  always #5 clk = ~clk;

  vector_lsu dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_cmd_store      (cmd_store),
    .i_cmd_addr       (cmd_addr),
    .i_cmd_stride     (cmd_stride),
    .i_cmd_count      (cmd_count),
    .i_cmd_reg        (cmd_reg),
    .o_busy           (busy),
    .o_done           (done),
    .o_mem_re         (mem_re),
    .o_mem_we         (mem_we),
    .o_mem_address    (mem_address),
    .o_mem_write_data (mem_write_data),
    .i_mem_data_out   (mem_data_out),
    .o_rf_raddr       (rf_raddr),
    .i_rf_rdata       (rf_rdata),
    .o_rf_we          (rf_we),
    .o_rf_waddr       (rf_waddr),
    .o_rf_wdata       (rf_wdata)
  );

  // Environment: Dmem writes on negedge, register file writes on posedge
  always @(negedge clk) begin
    if (mem_we)
      for (int i = 0; i < 16; i++)
        dmem[mem_address + 9'(i)] <= mem_write_data[511-32*i -: 32];
  end

  always @(posedge clk) begin
    if (rf_we) vrf[rf_waddr] <= rf_wdata;
  end

  always_comb begin
    mem_data_out = '0;
    for (int i = 0; i < 16; i++)
      mem_data_out[511-32*i -: 32] = dmem[mem_address + 9'(i)];
  end

  assign rf_rdata = vrf[rf_raddr];

  function automatic logic [511:0] gvec(input logic [8:0] a);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[511-32*i -: 32] = gmem[a + 9'(i)];
    return v;
  endfunction

  function automatic logic [8:0] beat_addr(input logic [8:0] a, input logic [8:0] s, input int k);
    return 9'(int'(a) + k * int'(s));
  endfunction

  task automatic gold_store_beat(input logic [8:0] a, input logic [1:0] r);
    for (int i = 0; i < 16; i++) gmem[a + 9'(i)] = gvrf[r][511-32*i -: 32];
  endtask

  // Called one time unit after the accept edge; returns one time unit into the done cycle
  task automatic check_beats(input logic st, input logic [8:0] a, input logic [8:0] s,
                             input logic [1:0] c, input logic [1:0] r);
    logic [8:0] ea;
    logic [1:0] er;
    logic [511:0] ev;
    for (int k = 0; k <= int'(c); k++) begin
      ea = beat_addr(a, s, k);
      er = 2'((int'(r) + k) % 4);
      checks++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0 || mem_re !== !st || mem_we !== st ||
          rf_we !== !st || done !== 1'b0)
        begin errors++; $display("FAIL beat_ctl k=%0d got busy=%b re=%b we=%b rfwe=%b done=%b exp store=%b",
                                  k, busy, mem_re, mem_we, rf_we, done, st); end
      checks++;
      if (mem_address !== ea)
        begin errors++; $display("FAIL beat_addr k=%0d got %h exp %h", k, mem_address, ea); end
      if (st) begin
        checks++;
        if (rf_raddr !== er)
          begin errors++; $display("FAIL rf_raddr k=%0d got %0d exp %0d", k, rf_raddr, er); end
        checks++;
        if (mem_write_data !== gvrf[er])
          begin errors++; $display("FAIL wdata k=%0d got %h exp %h", k, mem_write_data, gvrf[er]); end
      end else begin
        checks++;
        if (rf_waddr !== er)
          begin errors++; $display("FAIL rf_waddr k=%0d got %0d exp %0d", k, rf_waddr, er); end
        ev = gvec(ea);
        checks++;
        if (rf_wdata !== ev)
          begin errors++; $display("FAIL rf_wdata k=%0d got %h exp %h", k, rf_wdata, ev); end
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k <= int'(c); k++) begin
      ea = beat_addr(a, s, k);
      er = 2'((int'(r) + k) % 4);
      if (st) gold_store_beat(ea, er);
      else    gvrf[er] = gvec(ea);
    end
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || mem_re !== 1'b0 ||
        mem_we !== 1'b0 || rf_we !== 1'b0)
      begin errors++; $display("FAIL done_cycle got done=%b ready=%b busy=%b re=%b we=%b rfwe=%b exp 1 1 0 0 0 0",
                                done, cmd_ready, busy, mem_re, mem_we, rf_we); end
  endtask

  task automatic drive_cmd(input logic st, input logic [8:0] a, input logic [8:0] s,
                           input logic [1:0] c, input logic [1:0] r);
    cmd_valid = 1'b1; cmd_store = st; cmd_addr = a; cmd_stride = s; cmd_count = c; cmd_reg = r;
  endtask

  task automatic scramble_cmd();
    cmd_store = 1'($urandom); cmd_addr = 9'($urandom); cmd_stride = 9'($urandom);
    cmd_count = 2'($urandom); cmd_reg = 2'($urandom);
  endtask

  task automatic do_cmd(input logic st, input logic [8:0] a, input logic [8:0] s,
                        input logic [1:0] c, input logic [1:0] r);
    @(negedge clk);
    drive_cmd(st, a, s, c, r);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    scramble_cmd();
    check_beats(st, a, s, c, r);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1)
      begin errors++; $display("FAIL done_pulse got done=%b ready=%b exp 0 1", done, cmd_ready); end
  endtask

  task automatic check_state(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 512; i++) if (dmem[i] !== gmem[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s_mem got %0d differing words exp 0", tag, bad); end
    bad = 0;
    for (int i = 0; i < 4; i++) if (vrf[i] !== gvrf[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s_vrf got %0d differing regs exp 0", tag, bad); end
  endtask

  task automatic test_reset();
    logic [8:0] a;
    #2;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_re !== 1'b0 ||
        mem_we !== 1'b0 || rf_we !== 1'b0 || mem_address !== 9'd0)
      begin errors++; $display("FAIL reset_state got ready=%b busy=%b done=%b re=%b we=%b rfwe=%b addr=%h",
                                cmd_ready, busy, done, mem_re, mem_we, rf_we, mem_address); end
    @(negedge clk); rst = 1'b0;
    // A load beat interrupted before its closing edge must not write the register file
    a = 9'($urandom);
    @(negedge clk);
    drive_cmd(1'b0, a, 9'd5, 2'd1, 2'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (mem_re !== 1'b1 || mem_address !== a)
      begin errors++; $display("FAIL abort_load_beat got re=%b addr=%h exp 1 %h", mem_re, mem_address, a); end
    #2; rst = 1'b1; #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_re !== 1'b0 ||
        mem_we !== 1'b0 || rf_we !== 1'b0 || mem_address !== 9'd0)
      begin errors++; $display("FAIL async_reset got ready=%b busy=%b done=%b re=%b we=%b rfwe=%b addr=%h",
                                cmd_ready, busy, done, mem_re, mem_we, rf_we, mem_address); end
    @(negedge clk); rst = 1'b0;
    check_state("reset");
  endtask

  task automatic test_load_single();
    for (int i = 0; i < 16; i++) begin dmem[9'h010 + 9'(i)] = 32'(i); gmem[9'h010 + 9'(i)] = 32'(i); end
    do_cmd(1'b0, 9'h010, 9'($urandom), 2'd0, 2'd2);
    checks++;
    if (vrf[2][511:480] !== 32'd0 || vrf[2][31:0] !== 32'd15)
      begin errors++; $display("FAIL load1_words got %h..%h exp 0..f", vrf[2][511:480], vrf[2][31:0]); end
    check_state("load1");
  endtask

  task automatic test_store_strided();
    logic [511:0] v3;
    v3 = gvrf[3];
    do_cmd(1'b1, 9'h1F8, 9'h010, 2'd3, 2'd3);
    checks++;
    if (dmem[9'h1F8] !== v3[511:480] || dmem[9'h007] !== v3[31:0])
      begin errors++; $display("FAIL store_wrap got %h %h exp %h %h",
                                dmem[9'h1F8], dmem[9'h007], v3[511:480], v3[31:0]); end
    check_state("store4");
  endtask

  task automatic test_stride0();
    do_cmd(1'b0, 9'($urandom), 9'd0, 2'd2, 2'd3);
    checks++;
    if (vrf[3] !== vrf[0] || vrf[0] !== vrf[1])
      begin errors++; $display("FAIL stride0_same got %h %h %h", vrf[3][31:0], vrf[0][31:0], vrf[1][31:0]); end
    check_state("stride0");
  endtask

  task automatic test_back_to_back();
    logic [8:0] a1, a2, s2;
    logic [1:0] r1, r2;
    a1 = 9'($urandom); a2 = 9'($urandom); s2 = 9'($urandom);
    r1 = 2'($urandom); r2 = 2'($urandom);
    @(negedge clk);
    drive_cmd(1'b0, a1, 9'h021, 2'd3, r1);
    @(posedge clk); #1;
    // Second command offered from the first beat onward; must wait for the done cycle
    drive_cmd(1'b1, a2, s2, 2'd2, r2);
    check_beats(1'b0, a1, 9'h021, 2'd3, r1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_beats(1'b1, a2, s2, 2'd2, r2);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1)
      begin errors++; $display("FAIL b2b_done_pulse got done=%b ready=%b exp 0 1", done, cmd_ready); end
    check_state("b2b");
  endtask

  task automatic test_abort_store();
    logic [8:0] a;
    logic [1:0] r;
    a = 9'($urandom); r = 2'($urandom);
    @(negedge clk);
    drive_cmd(1'b1, a, 9'h040, 2'd3, r);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (mem_we !== 1'b1 || mem_address !== beat_addr(a, 9'h040, 2))
      begin errors++; $display("FAIL abort_beat2 got we=%b addr=%h exp 1 %h",
                                mem_we, mem_address, beat_addr(a, 9'h040, 2)); end
    rst = 1'b1; #1;
    checks++;
    if (mem_we !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL abort_idle got we=%b ready=%b busy=%b done=%b", mem_we, cmd_ready, busy, done); end
    for (int k = 0; k < 2; k++) gold_store_beat(beat_addr(a, 9'h040, k), 2'((int'(r) + k) % 4));
    @(negedge clk); rst = 1'b0;
    check_state("abort");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++)
      do_cmd(1'($urandom), 9'($urandom), 9'($urandom), 2'($urandom), 2'($urandom));
    check_state("random");
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin dmem[i] = $urandom; gmem[i] = dmem[i]; end
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < 16; w++) vrf[i][32*w +: 32] = $urandom;
      gvrf[i] = vrf[i];
    end
    test_reset();
    test_load_single();
    test_store_strided();
    test_stride0();
    test_back_to_back();
    test_abort_store();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
